// File: rtl/moldudp64_splitter.sv
// MoldUDP64 datagram splitter: strips the 20-byte header and tracks sequence
// numbers. Message blocks (length prefix plus body) go out through a byte FIFO.
// A truncated block is padded with zeros so the downstream parser stays framed.
// Optional macro SEQ_CHECK_EN enables sequence filtering: stale packets are
// dropped, and a gap_o pulse marks a packet that is ahead of the expected number.
module moldudp64_splitter #(
    parameter int FIFO_DEPTH = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  data_i,
    input  logic        valid_i,
    input  logic        last_i,
    output logic        ready_o,
    output logic [7:0]  data_o,
    output logic        valid_o,
    input  logic        ready_i,
    output logic [63:0] seq_num_o,
    output logic        gap_o,
    output logic        pkt_done_o,
    output logic [15:0] drop_cnt_o
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_HDR, S_LEN_HI, S_LEN_LO, S_BODY, S_PAD, S_DRAIN
    } state_t;

    state_t        state, state_n;
    logic [4:0]    byte_cnt, byte_cnt_n;
    logic [63:0]   seq_reg, seq_n;
    logic [7:0]    cnt_hi, cnt_hi_n;
    logic [15:0]   count_total, count_total_n;
    logic [15:0]   blk_left, blk_left_n;
    logic [7:0]    len_hi, len_hi_n;
    logic [15:0]   rem, rem_n;
    logic [16:0]   pad_rem, pad_rem_n;
    logic          drain_hb, drain_hb_n;

    logic          push, pop, accept, blk_end;
    logic [7:0]    push_data;
    logic          done_p, gap_p, drop_p, seq_load;
    logic          seq_old, seq_ahead;
    logic [15:0]   hdr_count, len_full;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   fifo_cnt;
    logic          fifo_full, fifo_empty;

    assign fifo_full  = (fifo_cnt == (AW+1)'(FIFO_DEPTH));
    assign fifo_empty = (fifo_cnt == '0);
    assign valid_o    = !fifo_empty;
    assign data_o     = fifo_empty ? 8'h00 : mem[rd_ptr];
    assign pop        = valid_o && ready_i;
    assign accept     = valid_i && ready_o;
    assign hdr_count  = {cnt_hi, data_i};
    assign len_full   = {len_hi, data_i};

`ifdef SEQ_CHECK_EN
    assign seq_old   = (seq_reg < seq_num_o);
    assign seq_ahead = (seq_reg > seq_num_o);
`else
    assign seq_old   = 1'b0;
    assign seq_ahead = 1'b0;
`endif

    // Upstream may push only while the current state can take a byte
    always_comb begin
        case (state)
            S_HDR, S_DRAIN:             ready_o = 1'b1;
            S_LEN_HI, S_LEN_LO, S_BODY: ready_o = !fifo_full;
            default:                    ready_o = 1'b0;
        endcase
    end

    // Next-state, datapath next values and event pulses for the framing FSM
    always_comb begin
        state_n       = state;
        byte_cnt_n    = byte_cnt;
        seq_n         = seq_reg;
        cnt_hi_n      = cnt_hi;
        count_total_n = count_total;
        blk_left_n    = blk_left;
        len_hi_n      = len_hi;
        rem_n         = rem;
        pad_rem_n     = pad_rem;
        drain_hb_n    = drain_hb;
        push          = 1'b0;
        push_data     = data_i;
        done_p        = 1'b0;
        gap_p         = 1'b0;
        drop_p        = 1'b0;
        seq_load      = 1'b0;
        blk_end       = 1'b0;

        case (state)
            S_HDR: begin
                if (accept) begin
                    byte_cnt_n = byte_cnt + 5'd1;
                    if (byte_cnt >= 5'd10 && byte_cnt <= 5'd17) begin
                        seq_n = {seq_reg[55:0], data_i};
                    end
                    if (byte_cnt == 5'd18) begin
                        cnt_hi_n = data_i;
                    end
                    if (byte_cnt == 5'd19) begin
                        byte_cnt_n    = 5'd0;
                        count_total_n = hdr_count;
                        blk_left_n    = hdr_count;
                        if (hdr_count == 16'h0000 || hdr_count == 16'hFFFF) begin
                            if (last_i) begin
                                done_p = 1'b1;
                            end else begin
                                drain_hb_n = 1'b1;
                                state_n    = S_DRAIN;
                            end
                        end else if (seq_old) begin
                            drop_p = 1'b1;
                            if (!last_i) begin
                                drain_hb_n = 1'b0;
                                state_n    = S_DRAIN;
                            end
                        end else begin
                            gap_p = seq_ahead;
                            if (last_i) begin
                                drop_p = 1'b1;
                            end else begin
                                state_n = S_LEN_HI;
                            end
                        end
                    end else if (last_i) begin
                        byte_cnt_n = 5'd0;
                        drop_p     = 1'b1;
                    end
                end
            end
            S_LEN_HI: begin
                if (accept) begin
                    push     = 1'b1;
                    len_hi_n = data_i;
                    if (last_i) begin
                        pad_rem_n = {1'b0, data_i, 8'h00} + 17'd1;
                        drop_p    = 1'b1;
                        state_n   = S_PAD;
                    end else begin
                        state_n = S_LEN_LO;
                    end
                end
            end
            S_LEN_LO: begin
                if (accept) begin
                    push  = 1'b1;
                    rem_n = len_full;
                    if (len_full == 16'd0) begin
                        blk_end = 1'b1;
                    end else if (last_i) begin
                        pad_rem_n = {1'b0, len_full};
                        drop_p    = 1'b1;
                        state_n   = S_PAD;
                    end else begin
                        state_n = S_BODY;
                    end
                end
            end
            S_BODY: begin
                if (accept) begin
                    push  = 1'b1;
                    rem_n = rem - 16'd1;
                    if (rem == 16'd1) begin
                        blk_end = 1'b1;
                    end else if (last_i) begin
                        pad_rem_n = {1'b0, rem - 16'd1};
                        drop_p    = 1'b1;
                        state_n   = S_PAD;
                    end
                end
            end
            S_PAD: begin
                if (!fifo_full) begin
                    push      = 1'b1;
                    push_data = 8'h00;
                    pad_rem_n = pad_rem - 17'd1;
                    if (pad_rem == 17'd1) begin
                        state_n = S_HDR;
                    end
                end
            end
            S_DRAIN: begin
                if (accept && last_i) begin
                    done_p  = drain_hb;
                    state_n = S_HDR;
                end
            end
            default: state_n = S_HDR;
        endcase

        if (blk_end) begin
            blk_left_n = blk_left - 16'd1;
            if (blk_left == 16'd1) begin
                if (last_i) begin
                    done_p   = 1'b1;
                    seq_load = 1'b1;
                    state_n  = S_HDR;
                end else begin
                    drop_p     = 1'b1;
                    drain_hb_n = 1'b0;
                    state_n    = S_DRAIN;
                end
            end else if (last_i) begin
                drop_p  = 1'b1;
                state_n = S_HDR;
            end else begin
                state_n = S_LEN_HI;
            end
        end
    end

    // Framing state, header fields, counters and status pulses
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_HDR;
            byte_cnt    <= 5'd0;
            seq_reg     <= 64'd0;
            cnt_hi      <= 8'd0;
            count_total <= 16'd0;
            blk_left    <= 16'd0;
            len_hi      <= 8'd0;
            rem         <= 16'd0;
            pad_rem     <= 17'd0;
            drain_hb    <= 1'b0;
            seq_num_o   <= 64'd1;
            drop_cnt_o  <= 16'd0;
            gap_o       <= 1'b0;
            pkt_done_o  <= 1'b0;
        end else begin
            state       <= state_n;
            byte_cnt    <= byte_cnt_n;
            seq_reg     <= seq_n;
            cnt_hi      <= cnt_hi_n;
            count_total <= count_total_n;
            blk_left    <= blk_left_n;
            len_hi      <= len_hi_n;
            rem         <= rem_n;
            pad_rem     <= pad_rem_n;
            drain_hb    <= drain_hb_n;
            gap_o       <= gap_p;
            pkt_done_o  <= done_p;
            if (seq_load) begin
                seq_num_o <= seq_reg + {48'd0, count_total};
            end
            if (drop_p && drop_cnt_o != 16'hFFFF) begin
                drop_cnt_o <= drop_cnt_o + 16'd1;
            end
        end
    end

    // FIFO pointers and occupancy; a reset throws away queued bytes
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            fifo_cnt <= fifo_cnt + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    // FIFO storage
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: tb/tb_moldudp64_splitter.sv
// Testbench for moldudp64_splitter: directed and randomized datagrams checked
// against a byte-level datagram model. Build with SEQ_CHECK_EN to also cover
// sequence filtering.
module tb_moldudp64_splitter;

    localparam int FIFO_DEPTH = 64;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  data_i;
    logic        valid_i;
    logic        last_i;
    logic        ready_o;
    logic [7:0]  data_o;
    logic        valid_o;
    logic        ready_i;
    logic [63:0] seq_num_o;
    logic        gap_o;
    logic        pkt_done_o;
    logic [15:0] drop_cnt_o;

    int checks = 0;
    int errors = 0;

    logic [7:0]  pkt[$];
    logic [7:0]  exp_q[$];
    logic [63:0] exp_seq = 64'd1;
    int exp_drop = 0, exp_done = 0, exp_gap = 0;
    int done_seen = 0, gap_seen = 0;
    int rdy_mode = 1;
    int fwd;

    always #5 clk = ~clk;

    moldudp64_splitter #(.FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .data_i     (data_i),
        .valid_i    (valid_i),
        .last_i     (last_i),
        .ready_o    (ready_o),
        .data_o     (data_o),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .seq_num_o  (seq_num_o),
        .gap_o      (gap_o),
        .pkt_done_o (pkt_done_o),
        .drop_cnt_o (drop_cnt_o)
    );

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic void build_hdr(input logic [63:0] seq, input logic [15:0] cnt);
        pkt.delete();
        for (int i = 0; i < 10; i++) pkt.push_back(8'($urandom));
        for (int i = 7; i >= 0; i--) pkt.push_back(seq[i*8 +: 8]);
        pkt.push_back(cnt[15:8]);
        pkt.push_back(cnt[7:0]);
    endfunction

    function automatic void add_block(input int len, input logic [7:0] typ);
        pkt.push_back(8'(len >> 8));
        pkt.push_back(8'(len));
        for (int i = 0; i < len; i++) pkt.push_back((i == 0) ? typ : 8'($urandom));
    endfunction

    // Datagram-level model: walks the whole datagram and derives the forwarded
    // byte stream, drop/done/gap events and the next expected sequence number
    function automatic void model_packet();
        int n, pos, len, avail, blocks, cnt;
        logic [63:0] seq;
        n = pkt.size();
        if (n < 20) begin exp_drop++; return; end
        seq = 64'd0;
        for (int i = 10; i < 18; i++) seq = {seq[55:0], pkt[i]};
        cnt = int'({pkt[18], pkt[19]});
        if (cnt == 0 || cnt == 65535) begin exp_done++; return; end
`ifdef SEQ_CHECK_EN
        if (seq < exp_seq) begin exp_drop++; return; end
        if (seq > exp_seq) exp_gap++;
`endif
        if (n == 20) begin exp_drop++; return; end
        pos = 20;
        blocks = 0;
        while (1'b1) begin
            if (pos == n - 1) begin
                exp_q.push_back(pkt[pos]);
                exp_q.push_back(8'h00);
                for (int i = 0; i < int'(pkt[pos]) * 256; i++) exp_q.push_back(8'h00);
                exp_drop++;
                return;
            end
            len = int'(pkt[pos]) * 256 + int'(pkt[pos+1]);
            exp_q.push_back(pkt[pos]);
            exp_q.push_back(pkt[pos+1]);
            pos += 2;
            avail = n - pos;
            if (len > avail) begin
                for (int i = pos; i < n; i++) exp_q.push_back(pkt[i]);
                for (int i = 0; i < len - avail; i++) exp_q.push_back(8'h00);
                exp_drop++;
                return;
            end
            for (int i = pos; i < pos + len; i++) exp_q.push_back(pkt[i]);
            pos += len;
            blocks++;
            if (blocks == cnt) begin
                if (pos == n) begin
                    exp_done++;
                    exp_seq = seq + 64'(cnt);
                end else begin
                    exp_drop++;
                end
                return;
            end
            if (pos == n) begin exp_drop++; return; end
        end
    endfunction

    task automatic applyStimulus(input bit gaps);
        int waitc;
        for (int i = 0; i < pkt.size(); i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                valid_i = 1'b0;
                @(posedge clk); #1;
            end
            valid_i = 1'b1;
            data_i  = pkt[i];
            last_i  = (i == pkt.size() - 1);
            waitc = 0;
            while (!ready_o && waitc < 5000) begin
                @(posedge clk); #1;
                waitc++;
            end
            checks++;
            assert (ready_o === 1'b1) else begin
                errors++;
                $error("FAIL accept_timeout: ready_o observed %0b after %0d cycles, expected 1", ready_o, waitc);
            end
            if (ready_o !== 1'b1) begin
                valid_i = 1'b0;
                last_i  = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        valid_i = 1'b0;
        last_i  = 1'b0;
    endtask

    task automatic wait_idle();
        int c;
        c = 0;
        while ((exp_q.size() != 0 || valid_o) && c < 5000) begin
            @(posedge clk); #1;
            c++;
        end
        checks++;
        assert (exp_q.size() == 0 && valid_o === 1'b0) else begin
            errors++;
            $error("FAIL drain: observed %0d bytes pending, valid_o=%0b, expected 0/0", exp_q.size(), valid_o);
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic check_status(input string tag);
        checkOutput({tag, "_seq_num"}, seq_num_o, exp_seq);
        checkOutput({tag, "_drop_cnt"}, 64'(drop_cnt_o), 64'(exp_drop));
        checkOutput({tag, "_pkt_done"}, 64'(done_seen), 64'(exp_done));
        checkOutput({tag, "_gap"}, 64'(gap_seen), 64'(exp_gap));
    endtask

    task automatic run_packet(input string tag, input bit gaps);
        model_packet();
        applyStimulus(gaps);
        wait_idle();
        check_status(tag);
    endtask

    task automatic random_packet();
        int kind, sel, cnt, n;
        logic [63:0] seq;
        kind = $urandom_range(0, 9);
        sel  = $urandom_range(0, 5);
        seq  = exp_seq;
        if (sel == 4) seq = exp_seq + 64'd7;
        if (sel == 5 && exp_seq > 64'd1) seq = exp_seq - 64'd1;
        if (kind == 0) begin
            build_hdr({$urandom, $urandom}, ($urandom_range(0, 1) == 1) ? 16'h0000 : 16'hFFFF);
            if ($urandom_range(0, 1) == 1) begin
                for (int i = 0; i < $urandom_range(1, 5); i++) pkt.push_back(8'($urandom));
            end
        end else begin
            cnt = $urandom_range(1, 3);
            build_hdr(seq, 16'(cnt));
            for (int b = 0; b < cnt; b++) add_block($urandom_range(0, 40), 8'h41 + 8'(b));
            if (kind == 1) begin
                n = $urandom_range(1, 19);
                while (pkt.size() > n) void'(pkt.pop_back());
            end else if (kind == 2) begin
                n = $urandom_range(20, pkt.size() - 1);
                while (pkt.size() > n) void'(pkt.pop_back());
            end else if (kind == 3) begin
                for (int i = 0; i < $urandom_range(1, 4); i++) pkt.push_back(8'($urandom));
            end
        end
        rdy_mode = $urandom_range(1, 3);
        run_packet("rand", 1'b1);
    endtask

    // Parser side: drives ready_i and checks every popped byte against the model
    initial begin
        logic [8:0] expv;
        ready_i = 1'b0;
        forever begin
            @(negedge clk);
            case (rdy_mode)
                0:       ready_i = 1'b0;
                1:       ready_i = 1'b1;
                2:       ready_i = ~ready_i;
                default: ready_i = 1'($urandom_range(0, 1));
            endcase
            if (!reset) begin
                if (pkt_done_o) done_seen++;
                if (gap_o) gap_seen++;
                if (valid_o && ready_i) begin
                    if (exp_q.size() != 0) expv = {1'b0, exp_q.pop_front()};
                    else expv = 9'h1FF;
                    checks++;
                    assert ({1'b0, data_o} === expv) else begin
                        errors++;
                        $error("FAIL out_byte: observed %0h expected %0h (1ff means no byte expected)", data_o, expv);
                    end
                end
            end
        end
    end

    // Directed scenarios followed by randomized datagrams
    initial begin
        reset   = 1'b1;
        valid_i = 1'b0;
        last_i  = 1'b0;
        data_i  = 8'h00;
        rdy_mode = 1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_valid", 64'(valid_o), 64'd0);
        checkOutput("rst_data", 64'(data_o), 64'd0);
        checkOutput("rst_gap", 64'(gap_o), 64'd0);
        checkOutput("rst_done", 64'(pkt_done_o), 64'd0);
        checkOutput("rst_drop", 64'(drop_cnt_o), 64'd0);
        checkOutput("rst_seq", seq_num_o, 64'd1);
        checkOutput("rst_ready", 64'(ready_o), 64'd1);
        reset = 1'b0;
        @(posedge clk); #1;

        // single 36-byte 'A' message
        rdy_mode = 1;
        build_hdr(64'd1, 16'd1);
        add_block(36, 8'h41);
        run_packet("t1", 1'b0);
        checkOutput("t1_seq_const", seq_num_o, 64'd2);

        // two blocks under toggling backpressure
        rdy_mode = 2;
        build_hdr(64'd2, 16'd2);
        add_block(36, 8'h41);
        add_block(19, 8'h44);
        run_packet("t2", 1'b0);
        checkOutput("t2_seq_const", seq_num_o, 64'd4);

        // heartbeat leaves the sequence alone
        rdy_mode = 1;
        build_hdr(64'd5, 16'd0);
        run_packet("t3", 1'b0);
        checkOutput("t3_seq_const", seq_num_o, 64'd4);

`ifdef SEQ_CHECK_EN
        // ahead-of-sequence packet, then a stale one
        build_hdr(exp_seq + 64'd4, 16'd1);
        add_block(10, 8'h41);
        run_packet("t4a", 1'b0);
        build_hdr(exp_seq - 64'd4, 16'd1);
        add_block(10, 8'h41);
        run_packet("t4b", 1'b0);
`endif

        // truncated body: pad phase holds off upstream
        rdy_mode = 1;
        build_hdr(exp_seq, 16'd1);
        add_block(36, 8'h41);
        while (pkt.size() > 32) void'(pkt.pop_back());
        model_packet();
        applyStimulus(1'b0);
        checkOutput("t5_pad_ready", 64'(ready_o), 64'd0);
        wait_idle();
        check_status("t5");
        build_hdr(exp_seq, 16'd1);
        add_block(12, 8'h45);
        run_packet("t5_next", 1'b0);

        // stalled parser fills the FIFO, then reset mid-packet
        rdy_mode = 0;
        @(posedge clk); #1;
        build_hdr(exp_seq, 16'd1);
        add_block(200, 8'h41);
        fwd = 0;
        for (int i = 0; i < 120; i++) begin
            valid_i = 1'b1;
            data_i  = pkt[i];
            last_i  = 1'b0;
            if (!ready_o) break;
            @(posedge clk); #1;
            if (i >= 20) fwd++;
        end
        valid_i = 1'b0;
        checkOutput("t6_pushes", 64'(fwd), 64'(FIFO_DEPTH));
        checkOutput("t6_ready_low", 64'(ready_o), 64'd0);
        checkOutput("t6_valid_full", 64'(valid_o), 64'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        checkOutput("t6_rst_valid", 64'(valid_o), 64'd0);
        checkOutput("t6_rst_ready", 64'(ready_o), 64'd1);
        checkOutput("t6_rst_seq", seq_num_o, 64'd1);
        checkOutput("t6_rst_drop", 64'(drop_cnt_o), 64'd0);
        reset = 1'b0;
        exp_q.delete();
        exp_seq  = 64'd1;
        exp_drop = 0;
        exp_done = 0;
        exp_gap  = 0;
        done_seen = 0;
        gap_seen  = 0;
        rdy_mode = 1;
        build_hdr(64'd1, 16'd1);
        add_block(20, 8'h50);
        run_packet("t6_after", 1'b0);

        for (int k = 0; k < 25; k++) random_packet();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
